// File: rtl/display_shift_out.sv
// Encodes a BCD time value to four 7-segment bytes and shifts the 32-bit frame
// out to an external shift-register chain, then pulses the storage latch.
module display_shift_out #(
    parameter int SYS_CLK_HZ         = 5_000_000,
    parameter int SHIFT_CLK_HZ       = 1_000_000,
    parameter bit BLANK_LEADING_ZERO = 1'b1,
    parameter bit INVERT_SEGMENTS    = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_start,
    input  logic [3:0] i_hours_tens,
    input  logic [3:0] i_hours_ones,
    input  logic [3:0] i_minutes_tens,
    input  logic [3:0] i_minutes_ones,
    input  logic       i_colon,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_serial_data,
    output logic       o_serial_clk,
    output logic       o_serial_latch
);

    localparam int DIV   = SYS_CLK_HZ / SHIFT_CLK_HZ;
    localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] CLK_HIGH_FROM = DIV_W'(DIV - DIV / 2);

    generate
        if (DIV < 2) begin : g_div_check
            $error("display_shift_out: SYS_CLK_HZ / SHIFT_CLK_HZ must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic [4:0]       r_bit;
    logic [4:0]       w_bit_next;
    logic [31:0]      r_frame;
    logic [31:0]      w_frame_next;
    logic             r_done;
    logic             w_done_next;
    logic [7:0]       w_hours_tens_byte;
    logic [31:0]      w_frame_raw;
    logic [31:0]      w_frame_load;
    logic             w_div_wrap;

    // Segment order {g,f,e,d,c,b,a}; anything that is not a decimal digit is blank.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_comb begin
        w_hours_tens_byte = {1'b0, seg7(i_hours_tens)};
        if (BLANK_LEADING_ZERO && (i_hours_tens == 4'd0)) begin
            w_hours_tens_byte = 8'h00;
        end
        w_frame_raw  = {w_hours_tens_byte,
                        i_colon, seg7(i_hours_ones),
                        1'b0,    seg7(i_minutes_tens),
                        1'b0,    seg7(i_minutes_ones)};
        w_frame_load = INVERT_SEGMENTS ? ~w_frame_raw : w_frame_raw;
    end

    assign w_div_wrap = (r_div == DIV_LAST);

    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_frame_next = r_frame;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_SHIFT;
                    w_frame_next = w_frame_load;
                    w_div_next   = '0;
                    w_bit_next   = '0;
                end
            end
            ST_SHIFT: begin
                if (w_div_wrap) begin
                    w_div_next = '0;
                    if (r_bit == 5'd31) begin
                        w_state_next = ST_LATCH;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next = r_bit + 5'd1;
                    end
                end else begin
                    w_div_next = r_div + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (w_div_wrap) begin
                    w_div_next   = '0;
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_div_next = r_div + DIV_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A low enable freezes every register, so the outputs decoded below hold too.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_frame <= '0;
            r_done  <= 1'b0;
        end else if (i_en) begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_frame <= w_frame_next;
            r_done  <= w_done_next;
        end
    end

    // In LATCH the data pin keeps showing the final bit of the frame.
    always_comb begin
        o_busy         = (r_state != ST_IDLE);
        o_done         = r_done;
        o_serial_clk   = (r_state == ST_SHIFT) && (r_div >= CLK_HIGH_FROM);
        o_serial_latch = (r_state == ST_LATCH);
        o_serial_data  = 1'b0;
        if (r_state == ST_SHIFT) begin
            o_serial_data = r_frame[5'd31 - r_bit];
        end else if (r_state == ST_LATCH) begin
            o_serial_data = r_frame[0];
        end
    end

endmodule

// File: tb/tb_display_shift_out.sv
// Directed bench for display_shift_out: three instances (default, no blanking,
// inverted) share the inputs and are checked against hand-computed frames.
module tb_display_shift_out;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       start;
    logic [3:0] ht, ho, mt, mo;
    logic       colon;
    logic [2:0] busy, done, sdata, sclk, slatch;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap [3];
    int          edges [3];
    int          latchPulses [3];
    int          latchWidth [3];
    int          busyCycles, doneCount, doneK, minGap, maxGap, freezeDiffs;
    logic        busyLog [0:255];

    always #5 clk = ~clk;

    display_shift_out #(.SYS_CLK_HZ(5_000_000), .SHIFT_CLK_HZ(1_000_000),
                        .BLANK_LEADING_ZERO(1'b1), .INVERT_SEGMENTS(1'b0)) dutMain (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_start(start),
        .i_hours_tens(ht), .i_hours_ones(ho), .i_minutes_tens(mt), .i_minutes_ones(mo),
        .i_colon(colon), .o_busy(busy[0]), .o_done(done[0]), .o_serial_data(sdata[0]),
        .o_serial_clk(sclk[0]), .o_serial_latch(slatch[0]));

    display_shift_out #(.SYS_CLK_HZ(5_000_000), .SHIFT_CLK_HZ(1_000_000),
                        .BLANK_LEADING_ZERO(1'b0), .INVERT_SEGMENTS(1'b0)) dutNoBlank (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_start(start),
        .i_hours_tens(ht), .i_hours_ones(ho), .i_minutes_tens(mt), .i_minutes_ones(mo),
        .i_colon(colon), .o_busy(busy[1]), .o_done(done[1]), .o_serial_data(sdata[1]),
        .o_serial_clk(sclk[1]), .o_serial_latch(slatch[1]));

    display_shift_out #(.SYS_CLK_HZ(5_000_000), .SHIFT_CLK_HZ(1_000_000),
                        .BLANK_LEADING_ZERO(1'b1), .INVERT_SEGMENTS(1'b1)) dutInvert (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_start(start),
        .i_hours_tens(ht), .i_hours_ones(ho), .i_minutes_tens(mt), .i_minutes_ones(mo),
        .i_colon(colon), .o_busy(busy[2]), .o_done(done[2]), .o_serial_data(sdata[2]),
        .o_serial_clk(sclk[2]), .o_serial_latch(slatch[2]));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic setDigits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             input logic [3:0] d, input logic col);
        ht = a; ho = b; mt = c; mo = d; colon = col;
    endtask

    // Cycle k is the k-th cycle after the edge that accepts the start; outputs
    // are sampled on the falling edge, stimulus for the next edge is set right after.
    task automatic applyStimulus(input int maxK, input int startA, input int startB,
                                 input int changeK, input int enOffK, input int enOnK,
                                 input int resetK, input bit holdStart);
        logic [2:0] prevClk;
        logic [2:0] prevLatch;
        logic [4:0] frozenRef;
        int         lastEdge;
        prevClk = '0; prevLatch = '0; frozenRef = '0; lastEdge = 0;
        busyCycles = 0; doneCount = 0; doneK = 0; minGap = 1000; maxGap = 0; freezeDiffs = 0;
        for (int d = 0; d < 3; d++) begin
            cap[d] = '0; edges[d] = 0; latchPulses[d] = 0; latchWidth[d] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= maxK; k++) begin
            @(negedge clk);
            busyLog[k] = busy[0];
            if (busy[0]) busyCycles++;
            if (done[0]) begin
                doneCount++;
                if (doneK == 0) doneK = k;
            end
            for (int d = 0; d < 3; d++) begin
                if (sclk[d] && !prevClk[d]) begin
                    cap[d] = {cap[d][30:0], sdata[d]};
                    edges[d]++;
                    if (d == 0) begin
                        if (lastEdge != 0) begin
                            if (k - lastEdge < minGap) minGap = k - lastEdge;
                            if (k - lastEdge > maxGap) maxGap = k - lastEdge;
                        end
                        lastEdge = k;
                    end
                end
                if (slatch[d] && !prevLatch[d]) latchPulses[d]++;
                if (slatch[d]) latchWidth[d]++;
            end
            prevClk   = sclk;
            prevLatch = slatch;
            if (k == enOffK) frozenRef = {busy[0], done[0], sdata[0], sclk[0], slatch[0]};
            if (enOffK > 0 && k > enOffK && k <= enOnK &&
                {busy[0], done[0], sdata[0], sclk[0], slatch[0]} != frozenRef) freezeDiffs++;
            start = holdStart || (k == startA) || (k == startB);
            if (k == changeK) setDigits(4'd8, 4'd8, 4'd8, 4'd8, 1'b0);
            if (k == enOffK) en = 1'b0;
            if (k == enOnK) en = 1'b1;
            if (k == resetK) begin
                rst = 1'b1;
                #1;
                checkOutput("async reset outputs", {17'd0, busy, done, sdata, sclk, slatch}, 32'd0);
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int idleActivity;
        rst = 1'b1; en = 1'b1; start = 1'b0;
        setDigits(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset busy",  {31'd0, busy[0]},   32'd0);
        checkOutput("reset done",  {31'd0, done[0]},   32'd0);
        checkOutput("reset data",  {31'd0, sdata[0]},  32'd0);
        checkOutput("reset sclk",  {31'd0, sclk[0]},   32'd0);
        checkOutput("reset latch", {31'd0, slatch[0]}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle after reset", {27'd0, busy[0], done[0], sdata[0], sclk[0], slatch[0]}, 32'd0);

        $display("[TB] basic frame 1,2:5,9 colon on");
        setDigits(4'd1, 4'd2, 4'd5, 4'd9, 1'b1);
        applyStimulus(175, 0, 0, 0, 0, 0, 0, 1'b0);
        checkOutput("t1 frame main",   cap[0], 32'h06DB6D6F);
        checkOutput("t1 frame noblank", cap[1], 32'h06DB6D6F);
        checkOutput("t1 frame invert", cap[2], 32'hF9249290);
        checkOutput("t1 sclk edges",   edges[0], 32);
        checkOutput("t1 min gap",      minGap, 5);
        checkOutput("t1 max gap",      maxGap, 5);
        checkOutput("t1 latch pulses", latchPulses[0], 1);
        checkOutput("t1 latch width",  latchWidth[0], 5);
        checkOutput("t1 busy cycles",  busyCycles, 165);
        checkOutput("t1 done cycle",   doneK, 166);
        checkOutput("t1 done count",   doneCount, 1);

        $display("[TB] leading zero 0,7:0,0");
        setDigits(4'd0, 4'd7, 4'd0, 4'd0, 1'b0);
        applyStimulus(175, 0, 0, 0, 0, 0, 0, 1'b0);
        checkOutput("t2 frame main",    cap[0], 32'h00073F3F);
        checkOutput("t2 frame noblank", cap[1], 32'h3F073F3F);
        checkOutput("t2 frame invert",  cap[2], 32'hFFF8C0C0);

        $display("[TB] non-decimal digits");
        setDigits(4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
        applyStimulus(175, 0, 0, 0, 0, 0, 0, 1'b0);
        checkOutput("t3 blank colon main",   cap[0], 32'h00800000);
        checkOutput("t3 blank colon invert", cap[2], 32'hFF7FFFFF);
        setDigits(4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
        applyStimulus(175, 0, 0, 0, 0, 0, 0, 1'b0);
        checkOutput("t3 blank main",    cap[0], 32'h00000000);
        checkOutput("t3 blank noblank", cap[1], 32'h00000000);
        checkOutput("t3 blank invert",  cap[2], 32'hFFFFFFFF);

        $display("[TB] starts while busy and mid-frame digit change");
        setDigits(4'd2, 4'd3, 4'd4, 4'd6, 1'b0);
        applyStimulus(200, 10, 100, 50, 0, 0, 0, 1'b0);
        checkOutput("t4 frame",        cap[0], 32'h5B4F667D);
        checkOutput("t4 latch pulses", latchPulses[0], 1);
        checkOutput("t4 busy cycles",  busyCycles, 165);
        checkOutput("t4 done count",   doneCount, 1);

        $display("[TB] enable dropped for 20 cycles at bit 12");
        setDigits(4'd1, 4'd2, 4'd5, 4'd9, 1'b1);
        applyStimulus(200, 0, 0, 0, 64, 84, 0, 1'b0);
        checkOutput("t5 frame",        cap[0], 32'h06DB6D6F);
        checkOutput("t5 frozen diffs", freezeDiffs, 0);
        checkOutput("t5 busy cycles",  busyCycles, 185);
        checkOutput("t5 done cycle",   doneK, 186);
        checkOutput("t5 latch width",  latchWidth[0], 5);

        $display("[TB] start ignored while disabled in idle");
        @(negedge clk);
        en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t5 disabled start", {31'd0, busy[0]}, 32'd0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t5 start not queued", {31'd0, busy[0]}, 32'd0);

        $display("[TB] back-to-back frames with start held");
        applyStimulus(170, 0, 0, 0, 0, 0, 0, 1'b1);
        checkOutput("b2b busy last",  {31'd0, busyLog[165]}, 32'd1);
        checkOutput("b2b idle gap",   {31'd0, busyLog[166]}, 32'd0);
        checkOutput("b2b restart",    {31'd0, busyLog[167]}, 32'd1);
        checkOutput("b2b done cycle", doneK, 166);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset at bit 20");
        setDigits(4'd1, 4'd2, 4'd5, 4'd9, 1'b1);
        applyStimulus(200, 0, 0, 0, 0, 0, 103, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idleActivity = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy[0] || slatch[0] || sclk[0] || done[0]) idleActivity++;
        end
        checkOutput("t6 quiet after reset", idleActivity, 0);
        setDigits(4'd0, 4'd9, 4'd5, 4'd3, 1'b1);
        applyStimulus(175, 0, 0, 0, 0, 0, 0, 1'b0);
        checkOutput("t6 frame after reset", cap[0], 32'h00EF6D4F);
        checkOutput("t6 latch pulses",      latchPulses[0], 1);
        checkOutput("t6 done cycle",        doneK, 166);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
